// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture path.
// Consumed by i2s_edge_sync and i2s_receiver through import i2s_pkg::*.
package i2s_pkg;

  localparam int I2S_DATA_W   = 24;
  localparam int LOCK_TIMEOUT = 64;

  typedef logic signed [I2S_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchronizer for an asynchronous clock input with a registered rising-edge pulse.
// The pulse is one Clk wide and trails the raw edge by three Clk edges.
module i2s_edge_sync
  import i2s_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S stereo capture, oversampled in the Clk domain, one L/R frame per valid/ready handshake.
// Defining I2S_RX_MONO_MIX_EN adds mono_out, the floor average of each committed frame.
//
// state | meaning
// SYNC  | waiting for any LRCLK transition, data ignored
// ALIGN | first slot after a transition, captured then discarded
// RUN   | locked; left word held, frame committed at right->left boundary
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              SCLK,
  input  logic              LRCLK,
  input  logic              SDIN,
  input  logic              ready,
  input  logic              ovr_clr,
  output logic              valid,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              locked,
  output logic              overrun
`ifdef I2S_RX_MONO_MIX_EN
  ,
  output logic [DATA_W-1:0] mono_out
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TMR_W = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DATA_W);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  logic              w_sclk_rise;
  logic              r_lr_meta;
  logic              r_lr_sync;
  logic              r_sd_meta;
  logic              r_sd_sync;
  logic              r_bit_vld;
  logic              r_lr;
  logic              r_sd;
  logic              r_lr_prev;
  rx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_left_hold;
  logic [DATA_W-1:0] r_left_out;
  logic [DATA_W-1:0] r_right_out;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [TMR_W-1:0]  r_lock_tmr;
  logic              r_valid;
  logic              r_locked;
  logic              r_overrun;
  logic              w_boundary;
  logic              w_frame_done;
  logic              w_load;
  logic [DATA_W-1:0] w_word;

  i2s_edge_sync u_sclk_sync (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_async (SCLK),
    .o_rise  (w_sclk_rise)
  );

  // Data is stable around the SCLK rise, so the synced copies line up with the registered rise pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_lr_meta <= 1'b0;
      r_lr_sync <= 1'b0;
      r_sd_meta <= 1'b0;
      r_sd_sync <= 1'b0;
      r_bit_vld <= 1'b0;
      r_lr      <= 1'b0;
      r_sd      <= 1'b0;
    end else begin
      r_lr_meta <= LRCLK;
      r_lr_sync <= r_lr_meta;
      r_sd_meta <= SDIN;
      r_sd_sync <= r_sd_meta;
      r_bit_vld <= w_sclk_rise;
      if (w_sclk_rise) begin
        r_lr <= r_lr_sync;
        r_sd <= r_sd_sync;
      end
    end
  end

  // Mask shifts out to zero once the slot exceeds DATA_W bits, which drops surplus bits.
  assign w_word       = r_shift | (r_sd ? (MSB_MASK >> r_bit_cnt) : '0);
  assign w_boundary   = r_bit_vld && (r_lr != r_lr_prev);
  assign w_frame_done = w_boundary && (r_state == RUN) && r_lr_prev;
  assign w_load       = w_frame_done && (!r_valid || ready);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= SYNC;
      r_lr_prev   <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_lock_tmr  <= '0;
      r_left_hold <= '0;
      r_left_out  <= '0;
      r_right_out <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_bit_vld) begin
        r_lr_prev <= r_lr;
        case (r_state)
          SYNC: begin
            if (w_boundary) begin
              r_state    <= ALIGN;
              r_shift    <= '0;
              r_bit_cnt  <= '0;
              r_lock_tmr <= TMR_LOAD;
            end
          end
          ALIGN, RUN: begin
            if (w_boundary) begin
              r_shift    <= '0;
              r_bit_cnt  <= '0;
              r_lock_tmr <= TMR_LOAD;
              if (r_state == ALIGN) begin
                r_state  <= RUN;
                r_locked <= 1'b1;
              end else if (!r_lr_prev) begin
                r_left_hold <= w_word;
              end
            end else if (r_lock_tmr == '0) begin
              r_state   <= SYNC;
              r_locked  <= 1'b0;
              r_shift   <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_shift    <= w_word;
              r_bit_cnt  <= (r_bit_cnt == CNT_MAX) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
              r_lock_tmr <= r_lock_tmr - TMR_W'(1);
            end
          end
          default: begin
            r_state  <= SYNC;
            r_locked <= 1'b0;
          end
        endcase
      end

      if (w_load) begin
        r_left_out  <= r_left_hold;
        r_right_out <= w_word;
        r_valid     <= 1'b1;
      end else if (ready && r_valid) begin
        r_valid <= 1'b0;
      end

      // A drop on the same cycle as a clear still leaves the flag set.
      if (w_frame_done && r_valid && !ready)
        r_overrun <= 1'b1;
      else if (ovr_clr)
        r_overrun <= 1'b0;
    end
  end

  assign valid     = r_valid;
  assign left_out  = r_left_out;
  assign right_out = r_right_out;
  assign locked    = r_locked;
  assign overrun   = r_overrun;

`ifdef I2S_RX_MONO_MIX_EN
  logic [DATA_W:0]   w_mono_sum;
  logic [DATA_W-1:0] r_mono;

  assign w_mono_sum = {r_left_hold[DATA_W-1], r_left_hold} + {w_word[DATA_W-1], w_word};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_mono <= '0;
    else if (w_load)
      r_mono <= DATA_W'($signed(w_mono_sum) >>> 1);
  end

  assign mono_out = r_mono;
`endif

endmodule
